// File: rtl/div_requester_pkg.sv
// Shared encodings and helpers for the divide requester: funct3 codes, FSM states, operand/result shaping.
package div_requester_pkg;

    localparam int DIV_XLEN = 64;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // W forms: the divider takes result signs from bit 63, so signed ops must be sign-extended.
    function automatic logic [DIV_XLEN-1:0] prep_operand(input logic [DIV_XLEN-1:0] v,
                                                         input logic w, input logic sgn);
        if (!w) return v;
        return {{32{sgn & v[31]}}, v[31:0]};
    endfunction

    function automatic logic [DIV_XLEN-1:0] select_result(input logic [DIV_XLEN-1:0] quo,
                                                          input logic [DIV_XLEN-1:0] rem,
                                                          input logic is_rem, input logic w);
        logic [DIV_XLEN-1:0] sel;
        sel = is_rem ? rem : quo;
        return w ? {{32{sel[31]}}, sel[31:0]} : sel;
    endfunction

endpackage

// File: rtl/div_requester_if.sv
// Decode-side op/result handshake plus divider-side issue/response bus of the divide requester.
interface div_requester_if;
    logic                                   in_valid;
    logic                                   in_ready;
    logic [2:0]                             funct3;
    logic                                   is_w;
    logic [div_requester_pkg::DIV_XLEN-1:0] src1;
    logic [div_requester_pkg::DIV_XLEN-1:0] src2;
    logic                                   flush;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [div_requester_pkg::DIV_XLEN-1:0] result;
    logic                                   busy;
    logic                                   id_valid;
    logic                                   div_ena;
    logic                                   div_signed;
    logic                                   w;
    logic [div_requester_pkg::DIV_XLEN-1:0] dividend;
    logic [div_requester_pkg::DIV_XLEN-1:0] divisor;
    logic                                   ex_ready;
    logic                                   div_valid;
    logic [div_requester_pkg::DIV_XLEN-1:0] quotient;
    logic [div_requester_pkg::DIV_XLEN-1:0] remainder;

    modport slave (
        input  in_valid, funct3, is_w, src1, src2, flush, out_ready, div_valid, quotient, remainder,
        output in_ready, out_valid, result, busy, id_valid, div_ena, div_signed, w, dividend, divisor,
               ex_ready
    );

    modport master (
        output in_valid, funct3, is_w, src1, src2, flush, out_ready, div_valid, quotient, remainder,
        input  in_ready, out_valid, result, busy, id_valid, div_ena, div_signed, w, dividend, divisor,
               ex_ready
    );
endinterface

// File: rtl/div_special.sv
// Detects divide-by-zero and signed overflow on prepared operands and forms their architectural results.
// Latency: combinational; no backpressure.
module div_special
    import div_requester_pkg::*;
(
    input  logic [DIV_XLEN-1:0] dividend,
    input  logic [DIV_XLEN-1:0] divisor,
    input  logic                is_signed,
    input  logic                is_w,
    output logic                special,
    output logic [DIV_XLEN-1:0] quotient,
    output logic [DIV_XLEN-1:0] remainder
);

    logic div_zero;
    logic overflow;

    always_comb begin
        div_zero  = is_w ? (divisor[31:0] == 32'h0) : (divisor == '0);
        overflow  = is_signed &&
                    (is_w ? ((dividend[31:0] == 32'h8000_0000) && (divisor[31:0] == 32'hFFFF_FFFF))
                          : ((dividend == {1'b1, {(DIV_XLEN-1){1'b0}}}) && (divisor == '1)));
        special   = div_zero || overflow;
        quotient  = dividend;
        remainder = '0;
        if (div_zero) begin
            quotient  = '1;
            remainder = dividend;
        end
    end

endmodule

// File: rtl/div_requester.sv
// Divide/remainder requester: latches an M-extension op, issues it to the divider, returns the result.
// Latency: 1 cycle after accept for special ops, else 1 cycle after div_valid; result held until out_ready or flush.
module div_requester
    import div_requester_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter bit SPECIAL_BYPASS = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    div_requester_if.slave bus
);

    state_t          state, state_nxt;
    logic [2:0]      funct3_q;
    logic            is_w_q;
    logic [XLEN-1:0] dividend_q, divisor_q, result_q;
    logic            id_valid_q, ex_ready_q, out_valid_q;

    logic            in_signed, in_rem, q_rem, spec_hit, bypass, accept, capture;
    logic [XLEN-1:0] prep_a, prep_b, spec_quo, spec_rem, spec_result, div_result;

    assign in_signed = (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
    assign in_rem    = (bus.funct3 == F3_REM) || (bus.funct3 == F3_REMU);
    assign q_rem     = (funct3_q == F3_REM) || (funct3_q == F3_REMU);
    assign prep_a    = prep_operand(bus.src1, bus.is_w, in_signed);
    assign prep_b    = prep_operand(bus.src2, bus.is_w, in_signed);

    div_special u_special (
        .dividend  (prep_a),
        .divisor   (prep_b),
        .is_signed (in_signed),
        .is_w      (bus.is_w),
        .special   (spec_hit),
        .quotient  (spec_quo),
        .remainder (spec_rem)
    );

    assign bypass      = SPECIAL_BYPASS && spec_hit;
    assign accept      = bus.in_valid && (state == ST_IDLE);
    assign capture     = (state == ST_WAIT) && bus.div_valid && !bus.flush;
    assign spec_result = select_result(spec_quo, spec_rem, in_rem, bus.is_w);
    assign div_result  = select_result(bus.quotient, bus.remainder, q_rem, is_w_q);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.in_valid) state_nxt = bypass ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_nxt = bus.flush ? ST_DRAIN : ST_WAIT;
            // A flush racing the response has nothing left to drain.
            ST_WAIT: begin
                if (bus.flush)          state_nxt = bus.div_valid ? ST_IDLE : ST_DRAIN;
                else if (bus.div_valid) state_nxt = ST_DONE;
            end
            ST_DRAIN: if (bus.div_valid) state_nxt = ST_IDLE;
            ST_DONE:  if (bus.flush || bus.out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs come straight from flops so the divider never sees a decode glitch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            funct3_q    <= '0;
            is_w_q      <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            result_q    <= '0;
            id_valid_q  <= 1'b0;
            ex_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            id_valid_q  <= (state_nxt == ST_ISSUE);
            ex_ready_q  <= (state_nxt == ST_WAIT) || (state_nxt == ST_DRAIN);
            out_valid_q <= (state_nxt == ST_DONE);
            if (accept) begin
                funct3_q   <= bus.funct3;
                is_w_q     <= bus.is_w;
                dividend_q <= prep_a;
                divisor_q  <= prep_b;
                if (bypass) result_q <= spec_result;
            end
            if (capture) result_q <= div_result;
        end
    end

    assign bus.in_ready   = (state == ST_IDLE) && reset;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.id_valid   = id_valid_q;
    assign bus.div_ena    = id_valid_q;
    assign bus.ex_ready   = ex_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.div_signed = (funct3_q == F3_DIV) || (funct3_q == F3_REM);
    assign bus.w          = is_w_q;
    assign bus.dividend   = dividend_q;
    assign bus.divisor    = divisor_q;

endmodule

// File: tb/tb_div_requester.sv
// Bench for div_requester: directed vector table, multi-cycle flush/hold/reset sequences, random ops vs a RISC-V reference.
module tb_div_requester;
    import div_requester_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    div_requester_if dif();

    div_requester #(.XLEN(64), .SPECIAL_BYPASS(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dif.slave)
    );

    int n_pass      = 0;
    int n_total     = 0;
    int issue_count = 0;
    int stab_err    = 0;
    int div_lat     = 2;

    typedef struct {
        logic [2:0]  f3;
        bit          w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          iss;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic checki(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic checkb(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Architectural RISC-V M-extension result, computed directly on the 32- or 64-bit values.
    function automatic logic [63:0] ref_result(input logic [2:0] f3, input bit w,
                                               input logic [63:0] a, input logic [63:0] b,
                                               output bit special);
        bit sgn, rem;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        rem = (f3 == 3'b110) || (f3 == 3'b111);
        special = 1'b0;
        if (w) begin
            int sa, sb;
            int unsigned ua, ub;
            logic [31:0] q32, r32;
            ua = a[31:0]; ub = b[31:0]; sa = a[31:0]; sb = b[31:0];
            if (ub == 0) begin q32 = 32'hFFFF_FFFF; r32 = ua; special = 1'b1; end
            else if (sgn && sa == 32'sh8000_0000 && sb == -1) begin q32 = ua; r32 = 0; special = 1'b1; end
            else if (sgn) begin q32 = sa / sb; r32 = sa % sb; end
            else begin q32 = ua / ub; r32 = ua % ub; end
            return rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end else begin
            longint sa, sb;
            logic [63:0] q, r;
            sa = a; sb = b;
            if (b == 0) begin q = '1; r = a; special = 1'b1; end
            else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = 0; special = 1'b1; end
            else if (sgn) begin q = sa / sb; r = sa % sb; end
            else begin q = a / b; r = a % b; end
            return rem ? r : q;
        end
    endfunction

    // Divider environment: 64-bit divide of the presented operands, answered div_lat cycles after issue.
    initial begin : divider_model
        bit pend;
        int cnt;
        logic [63:0] q, r, op_a, op_b;
        logic op_s, op_w;
        pend = 0; cnt = 0;
        dif.div_valid = 1'b0; dif.quotient = '0; dif.remainder = '0;
        forever begin
            @(posedge clock);
            #1;
            dif.div_valid = 1'b0;
            if (!reset) begin
                pend = 0;
                continue;
            end
            if (pend) begin
                if (dif.dividend !== op_a || dif.divisor !== op_b || dif.div_signed !== op_s || dif.w !== op_w)
                    stab_err++;
                if (cnt == 0) begin
                    dif.div_valid = 1'b1; dif.quotient = q; dif.remainder = r; pend = 0;
                end else cnt--;
            end
            if (dif.id_valid) begin
                issue_count++;
                if (dif.div_ena !== 1'b1) stab_err++;
                op_a = dif.dividend; op_b = dif.divisor; op_s = dif.div_signed; op_w = dif.w;
                pend = 1; cnt = div_lat;
                if (op_b == 0) begin q = '1; r = op_a; end
                else if (op_s) begin
                    longint sa, sb;
                    sa = op_a; sb = op_b;
                    if (op_a == 64'h8000_0000_0000_0000 && op_b == '1) begin q = op_a; r = 0; end
                    else begin q = sa / sb; r = sa % sb; end
                end else begin q = op_a / op_b; r = op_a % op_b; end
            end
        end
    end

    task automatic run_op(input logic [2:0] f3, input bit w, input logic [63:0] a, input logic [63:0] b,
                          input bit fl, input bit rel,
                          output logic [63:0] res, output int lat, output int iss);
        int ic0;
        ic0 = issue_count;
        dif.funct3 = f3; dif.is_w = w; dif.src1 = a; dif.src2 = b; dif.flush = fl; dif.in_valid = 1'b1;
        tick();
        dif.in_valid = 1'b0; dif.flush = 1'b0;
        dif.src1 = {$urandom, $urandom}; dif.src2 = {$urandom, $urandom};
        dif.funct3 = 3'b100 | 3'($urandom_range(0, 3)); dif.is_w = ~w;
        lat = 1;
        while (!dif.out_valid && lat < 200) begin tick(); lat++; end
        res = dif.result;
        iss = issue_count - ic0;
        if (rel) begin dif.out_ready = 1'b1; tick(); dif.out_ready = 1'b0; end
    endtask

    task automatic present(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        dif.funct3 = f3; dif.is_w = 1'b0; dif.src1 = a; dif.src2 = b; dif.in_valid = 1'b1;
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic drain_check(input string nm);
        int bad, n;
        bit seen_dv;
        bad = 0; n = 0; seen_dv = 0;
        while (dif.busy && n < 100) begin
            if (!dif.ex_ready || dif.out_valid) bad++;
            if (dif.div_valid) seen_dv = 1;
            tick(); n++;
        end
        checki({nm, "_ex_ready_held"}, bad, 0);
        checkb({nm, "_left_on_div_valid"}, seen_dv, 1'b1);
        checkb({nm, "_idle"}, dif.busy, 1'b0);
        tick();
        checkb({nm, "_no_out_valid"}, dif.out_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[16];
        logic [63:0] res, exp, a, b;
        logic [2:0] f3;
        bit w, sp;
        int lat, iss;

        vt[0]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 1};
        vt[1]  = '{3'b111, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0000_000F, 1};
        vt[2]  = '{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0FFF_FFFF, 1};
        vt[3]  = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0};
        vt[4]  = '{3'b110, 1'b0, 64'h5, 64'h0, 64'h5, 0};
        vt[5]  = '{3'b101, 1'b0, 64'h5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        vt[6]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0};
        vt[7]  = '{3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0, 0};
        vt[8]  = '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 1};
        vt[9]  = '{3'b101, 1'b1, 64'hFFFF_FFFF_0000_0007, 64'h2, 64'h3, 1};
        vt[10] = '{3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vt[11] = '{3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h0000_ABCD_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1};
        vt[12] = '{3'b101, 1'b1, 64'h5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        vt[13] = '{3'b111, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000, 0};
        vt[14] = '{3'b101, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
        vt[15] = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1};

        dif.in_valid = 1'b0; dif.funct3 = 3'b100; dif.is_w = 1'b0; dif.src1 = '0; dif.src2 = '0;
        dif.flush = 1'b0; dif.out_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        checkb("rst_in_ready", dif.in_ready, 1'b0);
        checkb("rst_out_valid", dif.out_valid, 1'b0);
        checkb("rst_id_valid", dif.id_valid, 1'b0);
        checkb("rst_div_ena", dif.div_ena, 1'b0);
        checkb("rst_ex_ready", dif.ex_ready, 1'b0);
        checkb("rst_busy", dif.busy, 1'b0);
        check("rst_result", dif.result, 64'h0);
        check("rst_dividend", dif.dividend, 64'h0);
        check("rst_divisor", dif.divisor, 64'h0);
        reset = 1'b1;
        tick();
        checkb("idle_in_ready", dif.in_ready, 1'b1);

        div_lat = 2;
        for (int i = 0; i < 16; i++) begin
            run_op(vt[i].f3, vt[i].w, vt[i].a, vt[i].b, 1'b0, 1'b1, res, lat, iss);
            check($sformatf("vec%0d_result", i), res, vt[i].exp);
            checki($sformatf("vec%0d_issues", i), iss, vt[i].iss);
            checki($sformatf("vec%0d_latency", i), lat, (vt[i].iss != 0) ? 3 + div_lat : 1);
        end

        // Result held in DONE while the consumer stalls; no accept on the out_ready cycle.
        run_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, 1'b0, res, lat, iss);
        check("hold_result0", res, 64'hFFFF_FFFF_FFFF_FFF2);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkb($sformatf("hold%0d_out_valid", k), dif.out_valid, 1'b1);
            check($sformatf("hold%0d_result", k), dif.result, 64'hFFFF_FFFF_FFFF_FFF2);
            checkb($sformatf("hold%0d_in_ready", k), dif.in_ready, 1'b0);
        end
        dif.funct3 = 3'b100; dif.src1 = 64'd9; dif.src2 = 64'd3; dif.in_valid = 1'b1; dif.out_ready = 1'b1;
        checkb("ack_cycle_in_ready", dif.in_ready, 1'b0);
        tick();
        dif.in_valid = 1'b0; dif.out_ready = 1'b0;
        checkb("ack_no_new_accept", dif.busy, 1'b0);
        checkb("ack_out_valid_drop", dif.out_valid, 1'b0);

        // Flush ten cycles into the divide: drain until the divider answers.
        div_lat = 15;
        present(3'b100, 64'd1000, 64'd10);
        checkb("fl_wait_issue", dif.id_valid, 1'b1);
        repeat (10) tick();
        checkb("fl_wait_ex_ready", dif.ex_ready, 1'b1);
        dif.flush = 1'b1;
        tick();
        dif.flush = 1'b0;
        checkb("fl_wait_drain_busy", dif.busy, 1'b1);
        drain_check("fl_wait");
        div_lat = 2;
        run_op(3'b101, 1'b0, 64'd1000, 64'd10, 1'b0, 1'b1, res, lat, iss);
        check("fl_wait_next_result", res, 64'd100);

        // Flush during the issue cycle itself.
        div_lat = 3;
        present(3'b110, 64'd50, 64'd7);
        dif.flush = 1'b1;
        tick();
        dif.flush = 1'b0;
        drain_check("fl_issue");

        // Flush landing on the same cycle as div_valid.
        present(3'b100, 64'd77, 64'd7);
        for (int n = 0; n < 20 && !dif.div_valid; n++) tick();
        checkb("fl_coinc_div_valid", dif.div_valid, 1'b1);
        dif.flush = 1'b1;
        tick();
        dif.flush = 1'b0;
        checkb("fl_coinc_idle", dif.busy, 1'b0);
        checkb("fl_coinc_out_valid", dif.out_valid, 1'b0);

        // Flush in DONE together with out_ready, and flush in IDLE alongside an accept.
        run_op(3'b101, 1'b0, 64'd40, 64'd8, 1'b0, 1'b0, res, lat, iss);
        dif.flush = 1'b1; dif.out_ready = 1'b1;
        tick();
        dif.flush = 1'b0; dif.out_ready = 1'b0;
        checkb("fl_done_out_valid", dif.out_valid, 1'b0);
        checkb("fl_done_in_ready", dif.in_ready, 1'b1);
        run_op(3'b111, 1'b0, 64'd100, 64'd7, 1'b1, 1'b1, res, lat, iss);
        check("fl_idle_result", res, 64'd2);

        // Asynchronous reset in WAIT.
        div_lat = 20;
        present(3'b100, 64'd100, 64'd3);
        tick(); tick();
        reset = 1'b0;
        #1;
        checkb("rstw_out_valid", dif.out_valid, 1'b0);
        checkb("rstw_id_valid", dif.id_valid, 1'b0);
        checkb("rstw_div_ena", dif.div_ena, 1'b0);
        checkb("rstw_ex_ready", dif.ex_ready, 1'b0);
        checkb("rstw_busy", dif.busy, 1'b0);
        checkb("rstw_in_ready", dif.in_ready, 1'b0);
        check("rstw_result", dif.result, 64'h0);
        check("rstw_dividend", dif.dividend, 64'h0);
        tick();
        reset = 1'b1;
        tick();
        div_lat = 2;
        run_op(3'b100, 1'b0, 64'd100, 64'd3, 1'b0, 1'b1, res, lat, iss);
        check("rstw_next_result", res, 64'd33);

        for (int i = 0; i < 300; i++) begin
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = '1;
                2: begin a = 64'h8000_0000_0000_0000; b = '1; end
                3: begin a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF}; end
                4: b = {$urandom, 32'h0};
                5: b = 64'($urandom_range(1, 15));
                default: ;
            endcase
            div_lat = $urandom_range(0, 4);
            exp = ref_result(f3, w, a, b, sp);
            run_op(f3, w, a, b, 1'b0, 1'b1, res, lat, iss);
            check($sformatf("rnd%0d_result", i), res, exp);
            checki($sformatf("rnd%0d_issues", i), iss, sp ? 0 : 1);
            checki($sformatf("rnd%0d_latency", i), lat, sp ? 1 : 3 + div_lat);
        end

        checki("operands_stable_issue_to_response", stab_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
